// File: rtl/ela_mem_arbiter.sv
// ela_mem_arbiter: single-port frame SRAM arbiter for three requesters.
// Round-robin with lockable bursts, capped at MAX_BURST while others wait.
module ela_mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    lock,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [1:0] NONE = 2'd3;
    localparam logic [3:0] LIMIT = 4'(MAX_BURST - 1);

    logic [1:0] owner, last, idx, n1, n2;
    logic [3:0] bcnt;
    logic [2:0] rd_pend, own_oh, rr_sel, sel;
    logic       own_keep, lock_sel;

    function automatic logic [2:0] oh(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        n1 = nxt(last);
        n2 = nxt(n1);
        own_oh = (owner == NONE) ? 3'b000 : oh(owner);
        // the owner keeps the port unless it has used up its burst and someone else waits
        own_keep = |(req & own_oh) && !(bcnt >= LIMIT && |(req & ~own_oh));
        rr_sel = |(req & oh(n1))   ? oh(n1) :
                 |(req & oh(n2))   ? oh(n2) :
                 |(req & oh(last)) ? oh(last) : 3'b000;
        sel = rst ? 3'b000 : own_keep ? own_oh : rr_sel;
        idx = sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
        lock_sel = |(sel & lock);
    end

    assign gnt       = sel;
    assign mem_cen   = |sel;
    assign mem_wen   = |(sel & we);
    assign mem_addr  = sel[0] ? addr0 : sel[1] ? addr1 : sel[2] ? addr2 : '0;
    assign mem_wdata = !mem_wen ? '0 : sel[0] ? wdata0 : sel[1] ? wdata1 : wdata2;
    assign rvalid    = rd_pend;
    assign rdata     = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= NONE;
            last    <= 2'd2;
            bcnt    <= 4'd0;
            rd_pend <= 3'b000;
        end else begin
            rd_pend <= sel & ~we;
            if (|sel) begin
                last  <= idx;
                owner <= lock_sel ? idx : NONE;
                bcnt  <= (lock_sel && owner == idx) ? bcnt + 4'd1 : 4'd0;
            end else begin
                owner <= NONE;
                bcnt  <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_ela_mem_arbiter.sv
// tb_ela_mem_arbiter: directed plan scenarios plus randomized traffic checked
// every cycle against a behavioural arbiter/SRAM model.
module tb_ela_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req = '0, lock = '0, we = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [2:0]    gnt, rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_cen, mem_wen;
    logic [AW-1:0] mem_addr;

    ela_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 5) ? 8'h3C : 8'(i * 37 + 11);
    endfunction

    // write-first SRAM macro stand-in
    logic [DW-1:0] sram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_cen) begin
                if (mem_wen) sram[mem_addr] <= mem_wdata;
                mem_rdata <= mem_wen ? mem_wdata : sram[mem_addr];
            end
        end
    end

    int checks = 0, errors = 0;
    int m_owner, m_last, m_bcnt, g;
    logic [2:0]    exp_rv;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] shadow [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] a_of(input int i);
        return (i == 0) ? addr0 : (i == 1) ? addr1 : addr2;
    endfunction

    function automatic logic [DW-1:0] w_of(input int i);
        return (i == 0) ? wdata0 : (i == 1) ? wdata1 : wdata2;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last = 2;
        m_bcnt = 0;
        g = -1;
        exp_rv = '0;
    endtask

    task automatic eval_check();
        logic wr;
        #1;
        g = -1;
        if (!rst) begin
            if (m_owner >= 0 && req[m_owner] &&
                !(m_bcnt >= MB - 1 && (req & ~(3'b001 << m_owner)) != 3'b000))
                g = m_owner;
            else
                for (int k = 1; k <= 3; k++) begin
                    int j;
                    j = (m_last + k) % 3;
                    if (req[j]) begin
                        g = j;
                        break;
                    end
                end
        end
        wr = (g >= 0) && we[g];
        chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : 32'(1 << g));
        chk("mem_cen", 32'(mem_cen), 32'(g >= 0));
        chk("mem_wen", 32'(mem_wen), 32'(wr));
        chk("mem_addr", 32'(mem_addr), (g < 0) ? 32'd0 : 32'(a_of(g)));
        chk("mem_wdata", 32'(mem_wdata), wr ? 32'(w_of(g)) : 32'd0);
        chk("rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != 3'b000) chk("rdata", 32'(rdata), 32'(exp_rd));
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            exp_rv = (g >= 0 && !we[g]) ? 3'(1 << g) : 3'b000;
            if (g >= 0 && !we[g]) exp_rd = shadow[a_of(g)];
            if (g >= 0 && we[g]) shadow[a_of(g)] = w_of(g);
            if (g >= 0) begin
                if (lock[g]) begin
                    m_bcnt = (m_owner == g) ? (m_bcnt + 1) % 16 : 0;
                    m_owner = g;
                end else begin
                    m_owner = -1;
                    m_bcnt = 0;
                end
                m_last = g;
            end else begin
                m_owner = -1;
                m_bcnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i] = w;
        case (i)
            0: begin addr0 = a; wdata0 = d; end
            1: begin addr1 = a; wdata1 = d; end
            default: begin addr2 = a; wdata2 = d; end
        endcase
    endtask

    logic [2:0] pend = '0;
    logic [2:0] rr_seq [6];

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
        model_reset();
        req = 3'b111;
        @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_cen", 32'(mem_cen), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 3'b000;

        repeat (10) begin
            eval_check();
            chk("idle_cen", 32'(mem_cen), 32'd0);
            adv();
        end

        req = 3'b010;
        set_req(1, 1'b0, 10'd5, 8'h00);
        eval_check();
        chk("rd_gnt", 32'(gnt), 32'h2);
        chk("rd_addr", 32'(mem_addr), 32'd5);
        chk("rd_wen", 32'(mem_wen), 32'd0);
        adv();
        req = 3'b000;
        eval_check();
        chk("rd_rvalid", 32'(rvalid), 32'h2);
        chk("rd_rdata", 32'(rdata), 32'h3C);
        adv();

        do_reset();
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        req = 3'b111;
        lock = 3'b000;
        we = 3'b000;
        for (int i = 0; i < 6; i++) begin
            eval_check();
            chk("rr_gnt", 32'(gnt), 32'(rr_seq[i]));
            if (i > 0) chk("rr_rvalid", 32'(rvalid), 32'(rr_seq[i-1]));
            adv();
        end

        do_reset();
        lock = 3'b010;
        req = 3'b010;
        set_req(1, 1'b0, 10'd33, 8'h00);
        eval_check();
        chk("lk_gnt0", 32'(gnt), 32'h2);
        adv();
        req = 3'b011;
        set_req(0, 1'b0, 10'd65, 8'h00);
        set_req(1, 1'b0, 10'd97, 8'h00);
        eval_check();
        chk("lk_gnt1", 32'(gnt), 32'h2);
        adv();
        set_req(1, 1'b0, 10'd34, 8'h00);
        eval_check();
        chk("lk_gnt2", 32'(gnt), 32'h2);
        adv();
        set_req(1, 1'b1, 10'd65, 8'h80);
        eval_check();
        chk("lk_gnt3", 32'(gnt), 32'h2);
        adv();
        req = 3'b001;
        lock = 3'b000;
        eval_check();
        chk("lk_gnt4", 32'(gnt), 32'h1);
        adv();
        req = 3'b000;
        eval_check();
        chk("lk_rdata", 32'(rdata), 32'h80);
        adv();

        do_reset();
        lock = 3'b010;
        we = 3'b000;
        set_req(1, 1'b0, 10'd3, 8'h00);
        set_req(2, 1'b0, 10'd7, 8'h00);
        for (int i = 0; i < 20; i++) begin
            req = (i <= 8) ? 3'b110 : 3'b010;
            eval_check();
            if (i == 0 || i == 7 || i == 9) chk("bl_p1", 32'(gnt), 32'h2);
            if (i == 8) chk("bl_p2", 32'(gnt), 32'h4);
            adv();
        end

        lock = 3'b000;
        req = 3'b100;
        set_req(2, 1'b0, 10'd9, 8'h00);
        eval_check();
        chk("mr_gnt", 32'(gnt), 32'h4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mr_rst_gnt", 32'(gnt), 32'd0);
        chk("mr_rst_cen", 32'(mem_cen), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mr_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        req = 3'b101;
        set_req(0, 1'b0, 10'd11, 8'h00);
        eval_check();
        chk("mr_p0", 32'(gnt), 32'h1);
        adv();

        pend = req;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int greedy;
            greedy = (cyc / 250) % 4;
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && g == i) pend[i] = 1'b0;
                if (!pend[i] && (i == greedy || $urandom_range(0, 99) < 40)) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom));
                end
                lock[i] = (i == greedy) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            req = pend;
            if (cyc % 700 == 699) do_reset();
            eval_check();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
